// File: rtl/control_unit_if.sv
// Bus/strobe bundle between the nic8 control unit and its datapath.
// master = control unit, slave = datapath / front panel side.
interface control_unit_if;
  logic [7:0] BUS;
  logic       Z;
  logic       C;
  logic       RUN;
  logic       STEP;
  logic [7:0] ASSERT_B;
  logic [7:0] LOAD_B;
  logic       IR_LOAD;
  logic       PC_INC;
  logic       HALTED;
  logic [7:0] IR;

  modport master (
    input  BUS, Z, C, RUN, STEP,
    output ASSERT_B, LOAD_B, IR_LOAD, PC_INC, HALTED, IR
  );

  modport slave (
    output BUS, Z, C, RUN, STEP,
    input  ASSERT_B, LOAD_B, IR_LOAD, PC_INC, HALTED, IR
  );
endinterface

// File: rtl/control_unit.sv
// nic8 fetch/execute sequencer: owns IR, decodes active-low bus strobes, handles run/step/halt.
// Optional CONTROL_UNIT_COND_EN: IR[7:6] conditions gate LOAD_B on the Z/C flags.
module control_unit (
  input  logic           CLK,
  input  logic           RESET,
  control_unit_if.master bus_if
);

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_nx;
  logic [7:0] ir_q;
  logic [7:0] ir_nx;

  logic       run_meta;
  logic       run_s;
  logic       step_meta;
  logic       step_s;
  logic       step_prev;
  logic       step_pulse;

  logic [7:0] assert_q;
  logic [7:0] assert_nx;
  logic [7:0] load_q;
  logic [7:0] load_nx;
  logic       ir_load_q;
  logic       ir_load_nx;
  logic       pc_inc_q;
  logic       pc_inc_nx;
  logic       cond_ok;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      run_meta  <= bus_if.RUN;
      run_s     <= run_meta;
      step_meta <= bus_if.STEP;
      step_s    <= step_meta;
      step_prev <= step_s;
    end
  end

  assign step_pulse = step_s & ~step_prev;

  // Strobes are precomputed from the next state/IR so they come straight off flops.
  always_comb begin
    state_nx   = state_q;
    ir_nx      = ir_q;
    assert_nx  = 8'hFF;
    load_nx    = 8'hFF;
    ir_load_nx = 1'b0;
    pc_inc_nx  = 1'b0;

    case (state_q)
      PAUSE: if (run_s | step_pulse) state_nx = FETCH;
      FETCH: begin
        state_nx = EXEC;
        ir_nx    = bus_if.BUS;
      end
      EXEC: begin
        if (ir_q[5:0] == 6'h3F) state_nx = HALT;
        else if (run_s)         state_nx = FETCH;
        else                    state_nx = PAUSE;
      end
      HALT:    state_nx = HALT;
      default: state_nx = PAUSE;
    endcase

    case (state_nx)
      FETCH: begin
        assert_nx  = 8'hFE;
        ir_load_nx = 1'b1;
        pc_inc_nx  = 1'b1;
      end
      EXEC: begin
        if (ir_nx[2:0] != 3'd7) assert_nx[ir_nx[2:0]] = 1'b0;
        if (ir_nx[5:3] != 3'd7) load_nx[ir_nx[5:3]]   = 1'b0;
        pc_inc_nx = (ir_nx[2:0] == 3'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= PAUSE;
      ir_q      <= 8'h00;
      assert_q  <= 8'hFF;
      load_q    <= 8'hFF;
      ir_load_q <= 1'b0;
      pc_inc_q  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      ir_q      <= ir_nx;
      assert_q  <= assert_nx;
      load_q    <= load_nx;
      ir_load_q <= ir_load_nx;
      pc_inc_q  <= pc_inc_nx;
    end
  end

`ifdef CONTROL_UNIT_COND_EN
  // Flags are live during EXEC; load_q is all-ones in every other state anyway.
  always_comb begin
    cond_ok = 1'b1;
    case (ir_q[7:6])
      2'b00: cond_ok = 1'b1;
      2'b01: cond_ok = bus_if.Z;
      2'b10: cond_ok = bus_if.C;
      2'b11: cond_ok = ~bus_if.Z;
      default: cond_ok = 1'b1;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^{bus_if.Z, bus_if.C, ir_q[7:6]};
  assign cond_ok     = 1'b1;
`endif

  assign bus_if.ASSERT_B = assert_q;
  assign bus_if.LOAD_B   = cond_ok ? load_q : 8'hFF;
  assign bus_if.IR_LOAD  = ir_load_q;
  assign bus_if.PC_INC   = pc_inc_q;
  assign bus_if.HALTED   = (state_q == HALT);
  assign bus_if.IR       = ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode vectors, single-step, halt, async reset, random invariants.
module tb_control_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  control_unit_if cu_if ();

  control_unit dut (
    .CLK    (clk),
    .RESET  (reset),
    .bus_if (cu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] bus, input logic z, input logic c);
    cu_if.BUS = bus;
    cu_if.Z   = z;
    cu_if.C   = c;
  endtask

  task automatic applyReset(input logic run);
    reset      = 1'b1;
    cu_if.RUN  = run;
    cu_if.STEP = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_assert", cu_if.ASSERT_B, 8'hFF);
    checkOutput("rst_ir", cu_if.IR, 8'h00);
    reset = 1'b0;
  endtask

  // One instruction in free-run: FETCH cycle then EXEC cycle.
  task automatic runVector(input string tag, input logic [7:0] ir, input logic z, input logic c,
                           input logic [7:0] exp_a, input logic [7:0] exp_l_cond,
                           input logic [7:0] exp_l_nocond, input logic exp_pc);
    logic [7:0] exp_l;
`ifdef CONTROL_UNIT_COND_EN
    exp_l = exp_l_cond;
`else
    exp_l = exp_l_nocond;
`endif
    applyStimulus(ir, z, c);
    tick();
    checkOutput({tag, "_fetch_a"}, cu_if.ASSERT_B, 8'hFE);
    checkOutput({tag, "_fetch_irl"}, {7'b0, cu_if.IR_LOAD}, 8'h01);
    tick();
    checkOutput({tag, "_ir"}, cu_if.IR, ir);
    checkOutput({tag, "_a"}, cu_if.ASSERT_B, exp_a);
    checkOutput({tag, "_l"}, cu_if.LOAD_B, exp_l);
    checkOutput({tag, "_pc"}, {7'b0, cu_if.PC_INC}, {7'b0, exp_pc});
  endtask

  initial begin
    logic [7:0] r;
    total = 0;
    bad   = 0;
    reset = 1'b1;

    applyReset(1'b1);
    tick();
    checkOutput("fill1_a", cu_if.ASSERT_B, 8'hFF);
    checkOutput("fill1_irl", {7'b0, cu_if.IR_LOAD}, 8'h00);
    tick();
    checkOutput("fill2_irl", {7'b0, cu_if.IR_LOAD}, 8'h00);

    runVector("imm_a",   8'h08, 1'b0, 1'b0, 8'hFE, 8'hFD, 8'hFD, 1'b1);
    runVector("b_pc_z0", 8'h42, 1'b0, 1'b0, 8'hFB, 8'hFF, 8'hFE, 1'b0);
    runVector("b_pc_z1", 8'h42, 1'b1, 1'b0, 8'hFB, 8'hFE, 8'hFE, 1'b0);
    runVector("jmp_z0",  8'h40, 1'b0, 1'b0, 8'hFE, 8'hFF, 8'hFE, 1'b1);
    runVector("jmp_z1",  8'h40, 1'b1, 1'b0, 8'hFE, 8'hFE, 8'hFE, 1'b1);
    runVector("x_a_c0",  8'h8B, 1'b0, 1'b0, 8'hF7, 8'hFF, 8'hFD, 1'b0);
    runVector("x_a_c1",  8'h8B, 1'b0, 1'b1, 8'hF7, 8'hFD, 8'hFD, 1'b0);
    runVector("a_b_z1",  8'hD1, 1'b1, 1'b0, 8'hFD, 8'hFF, 8'hFB, 1'b0);
    runVector("a_b_z0",  8'hD1, 1'b0, 1'b0, 8'hFD, 8'hFB, 8'hFB, 1'b0);
    runVector("x_x",     8'h1B, 1'b0, 1'b0, 8'hF7, 8'hF7, 8'hF7, 1'b0);
    runVector("alu_none",8'h3C, 1'b0, 1'b0, 8'hEF, 8'hFF, 8'hFF, 1'b0);
    runVector("none_ram",8'h2F, 1'b0, 1'b0, 8'hFF, 8'hDF, 8'hDF, 1'b0);

    // Async reset in the middle of an X->X EXEC.
    applyStimulus(8'h1B, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("pre_rst_l", cu_if.LOAD_B, 8'hF7);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_a", cu_if.ASSERT_B, 8'hFF);
    checkOutput("async_rst_l", cu_if.LOAD_B, 8'hFF);
    checkOutput("async_rst_ir", cu_if.IR, 8'h00);
    checkOutput("async_rst_irl", {7'b0, cu_if.IR_LOAD}, 8'h00);

    // Single step with a second synchronized rise landing in EXEC.
    applyReset(1'b0);
    applyStimulus(8'h08, 1'b0, 1'b0);
    cu_if.STEP = 1'b1;
    tick();
    checkOutput("step_e1_irl", {7'b0, cu_if.IR_LOAD}, 8'h00);
    cu_if.STEP = 1'b0;
    tick();
    checkOutput("step_e2_irl", {7'b0, cu_if.IR_LOAD}, 8'h00);
    cu_if.STEP = 1'b1;
    tick();
    checkOutput("step_e3_irl", {7'b0, cu_if.IR_LOAD}, 8'h01);
    checkOutput("step_e3_a", cu_if.ASSERT_B, 8'hFE);
    tick();
    checkOutput("step_e4_a", cu_if.ASSERT_B, 8'hFE);
    checkOutput("step_e4_l", cu_if.LOAD_B, 8'hFD);
    for (int i = 5; i < 10; i++) begin
      tick();
      checkOutput("step_pause_a", cu_if.ASSERT_B, 8'hFF);
      checkOutput("step_pause_irl", {7'b0, cu_if.IR_LOAD}, 8'h00);
    end

    // Halt instruction, then RUN/STEP churn must not leave HALT.
    applyReset(1'b1);
    tick();
    tick();
    applyStimulus(8'h3F, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("halt_exec_a", cu_if.ASSERT_B, 8'hFF);
    checkOutput("halt_exec_l", cu_if.LOAD_B, 8'hFF);
    checkOutput("halt_exec_pc", {7'b0, cu_if.PC_INC}, 8'h00);
    checkOutput("halt_exec_h", {7'b0, cu_if.HALTED}, 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("halted", {7'b0, cu_if.HALTED}, 8'h01);
      checkOutput("halted_a", cu_if.ASSERT_B, 8'hFF);
      cu_if.RUN  = i[0];
      cu_if.STEP = i[1];
    end

    // Random instruction stream: strobe invariants every cycle.
    applyReset(1'b1);
    tick();
    tick();
    for (int i = 0; i < 1000; i++) begin
      r = 8'($urandom);
      if (r[5:0] == 6'h3F) r[0] = 1'b0;
      applyStimulus(r, 1'($urandom), 1'($urandom));
      tick();
      checkOutput("rnd_fetch_a", cu_if.ASSERT_B, 8'hFE);
      checkOutput("rnd_fetch_l", cu_if.LOAD_B, 8'hFF);
      tick();
      checkOutput("rnd_ir", cu_if.IR, r);
      checkOutput("rnd_a_onecold", {7'b0, ($countones(~cu_if.ASSERT_B) <= 1)}, 8'h01);
      checkOutput("rnd_l_onecold", {7'b0, ($countones(~cu_if.LOAD_B) <= 1)}, 8'h01);
      checkOutput("rnd_exec_irl", {7'b0, cu_if.IR_LOAD}, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
